vga_write_arbiter: RTL and testbench
====================================

// Module: vga_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single vga_adapter pixel-write port among N
//  drawing objects (player block, ground bar, obstacles). Each object holds req
//  for one full erase/move/draw cycle; the arbiter grants one at a time, muxes its
//  x/y/color/write to the adapter, and revokes grants held beyond MAX_HOLD cycles.
// PARAMETERS
//  N         4       number of requesters (2..8)
//  nX        10      pixel x width
//  nY        9       pixel y width
//  CW        9       color width
//  HOLD_W    17      width of hold-time counter
//  MAX_HOLD  100000  max cycles a grant may persist before forced revoke (< 2**HOLD_W)
// PORTS
//  CLOCK_50     in   1       system clock, all logic on rising edge
//  Resetn       in   1       synchronous, active-low reset
//  req          in   N       request per object, held high for whole drawing cycle
//  obj_x        in   N*nX    packed x coords, requester k at [k*nX +: nX]
//  obj_y        in   N*nY    packed y coords, requester k at [k*nY +: nY]
//  obj_color    in   N*CW    packed colors, requester k at [k*CW +: CW]
//  obj_write    in   N       per-object pixel write strobe
//  gnt          out  N       one-hot grant (registered)
//  VGA_x        out  nX      muxed pixel x to vga_adapter
//  VGA_y        out  nY      muxed pixel y
//  VGA_color    out  CW      muxed pixel color
//  VGA_write    out  1       muxed write strobe
//  busy         out  1       1 while in GRANT
//  timeout_err  out  N       sticky per-requester flag: grant was force-revoked
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, ptr=0, hold_cnt=0, lockout=0, timeout_err=0, busy=0.
//   Reset mid-grant drops gnt next edge; no pixel write occurs after reset edge.
//  States: IDLE, GRANT, GAP.
//  IDLE: eligible = req & ~lockout. If eligible!=0, choose first k scanning
//   ptr, ptr+1, ... wrapping mod N; next edge: state=GRANT, gnt=onehot(k),
//   hold_cnt=0. Latency req->gnt = 1 cycle when idle. eligible==0: stay IDLE.
//  GRANT: hold_cnt increments each cycle (saturates at MAX_HOLD).
//   req[k]==0 -> GAP, gnt=0, ptr=(k+1) mod N. Normal release, no flag.
//   req[k]==1 and hold_cnt==MAX_HOLD-1 -> GAP, gnt=0, ptr=(k+1) mod N,
//    lockout[k]=1, timeout_err[k]=1. Release and timeout in same cycle = release.
//  GAP: exactly one cycle, gnt=0, VGA_write=0; then IDLE. Guarantees a dead cycle
//   between owners so no pixel from the old owner lands with the new owner's coords.
//  lockout[k] clears on the first cycle req[k]==0; k is ineligible until then.
//  timeout_err cleared only by reset.
//  Mux (combinational from gnt): GRANT -> VGA_x/y/color = granted obj fields,
//   VGA_write = obj_write[k]. IDLE/GAP -> VGA_x/y/color = 0, VGA_write = 0.
//   obj_write from ungranted objects is ignored entirely.
//  Fairness: a requester waits at most N-1 other grants. No priority inversion:
//   ptr advances only on grant end, never in IDLE.
//  No arithmetic on coordinates; fields pass through unmodified at native width.
// TESTING
//  1 Reset, req=0001 at t0 -> gnt=0001 at t0+1, busy=1; obj_write[0]=1 with
//    x=80,y=400,color=9'h1C0 -> VGA_write=1, VGA_x=80, VGA_y=400, VGA_color=9'h1C0.
//  2 req=1111 held, each owner drops req after 10 cycles -> grant order 0,1,2,3,0;
//    exactly one GAP cycle with gnt=0 between consecutive grants.
//  3 ptr=2 (after grant to 1), req=0011 -> gnt=0001 (wrap), then gnt=0010.
//  4 MAX_HOLD=16, req[1] held forever -> gnt[1] drops after 16 GRANT cycles,
//    timeout_err=0010; req=0010 still high -> no regrant; drop req[1] 1 cycle,
//    raise again -> granted; timeout_err stays 0010.
//  5 Ungranted obj_write[2]=1 while gnt=0001, obj_write[0]=0 -> VGA_write=0.
//  6 Resetn=0 mid-grant at pixel 500 of a draw -> next edge gnt=0, VGA_write=0,
//    timeout_err=0; after release req=0100 -> gnt=0100 one cycle later (ptr=0 scan).

Source files
------------

// File: rtl/vga_write_arbiter_if.sv
// Object-side bus into the VGA write arbiter.
// Requests, packed pixel fields and one-hot grant.
interface vga_write_arbiter_if #(
  parameter int N  = 4,
  parameter int nX = 10,
  parameter int nY = 9,
  parameter int CW = 9
);
  logic [N-1:0]    req;
  logic [N*nX-1:0] obj_x;
  logic [N*nY-1:0] obj_y;
  logic [N*CW-1:0] obj_color;
  logic [N-1:0]    obj_write;
  logic [N-1:0]    gnt;

  modport master (
    output req,
    output obj_x,
    output obj_y,
    output obj_color,
    output obj_write,
    input  gnt
  );

  modport slave (
    input  req,
    input  obj_x,
    input  obj_y,
    input  obj_color,
    input  obj_write,
    output gnt
  );
endinterface

// File: rtl/vga_write_arbiter.sv
// Round-robin owner of the vga_adapter pixel port.
// Ports: CLOCK_50, Resetn (sync, low), bus (slave), VGA_*, busy, timeout_err.
module vga_write_arbiter #(
  parameter int N        = 4,
  parameter int nX       = 10,
  parameter int nY       = 9,
  parameter int CW       = 9,
  parameter int HOLD_W   = 17,
  parameter int MAX_HOLD = 100000
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  vga_write_arbiter_if.slave bus,
  output logic [nX-1:0] VGA_x,
  output logic [nY-1:0] VGA_y,
  output logic [CW-1:0] VGA_color,
  output logic          VGA_write,
  output logic          busy,
  output logic [N-1:0]  timeout_err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT =
    HOLD_W'(MAX_HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [PW-1:0]    own_q, own_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N-1:0]     lock_q, lock_d;
  logic [N-1:0]     terr_q, terr_d;

  logic [N-1:0]     elig;
  logic [PW:0]      scan_res;
  logic             pick_ok;
  logic [PW-1:0]    pick;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] a
  );
    if (int'(a) >= N - 1) return '0;
    return a + 1'b1;
  endfunction

  // Returns {found, index} of first set bit of e
  // scanning p, p+1, ... modulo N.
  function automatic logic [PW:0] scan(
    input logic [N-1:0]  e,
    input logic [PW-1:0] p
  );
    logic          f;
    logic [PW-1:0] idx;
    int            c;
    f   = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(p) + i;
      if (c >= N) c = c - N;
      if (!f && e[c[PW-1:0]]) begin
        f   = 1'b1;
        idx = c[PW-1:0];
      end
    end
    return {f, idx};
  endfunction

  assign elig     = bus.req & ~lock_q;
  assign scan_res = scan(elig, ptr_q);
  assign pick_ok  = scan_res[PW];
  assign pick     = scan_res[PW-1:0];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    terr_d  = terr_q;
    // A locked-out requester is freed once it lets go.
    lock_d  = lock_q & bus.req;
    unique case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          state_d = S_GRANT;
          gnt_d   = '0;
          gnt_d[pick] = 1'b1;
          own_d   = pick;
          hold_d  = '0;
        end
      end
      S_GRANT: begin
        if (!bus.req[own_q]) begin
          state_d = S_GAP;
          gnt_d   = '0;
          ptr_d   = wrap_inc(own_q);
        end else if (hold_q == HOLD_LAST) begin
          state_d       = S_GAP;
          gnt_d         = '0;
          ptr_d         = wrap_inc(own_q);
          lock_d[own_q] = 1'b1;
          terr_d[own_q] = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      lock_q  <= '0;
      terr_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      lock_q  <= lock_d;
      terr_q  <= terr_d;
    end
  end

  // gnt is one-hot or zero, so OR-ing the selected
  // fields is a plain mux; zero grant gives zeros.
  always_comb begin
    VGA_x     = '0;
    VGA_y     = '0;
    VGA_color = '0;
    VGA_write = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (gnt_q[k]) begin
        VGA_x     = VGA_x | bus.obj_x[k*nX +: nX];
        VGA_y     = VGA_y | bus.obj_y[k*nY +: nY];
        VGA_color = VGA_color
                  | bus.obj_color[k*CW +: CW];
        VGA_write = VGA_write | bus.obj_write[k];
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign busy        = (state_q == S_GRANT);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter.
// Short MAX_HOLD so forced revokes are quick.
module tb_vga_write_arbiter;

  localparam int N  = 4;
  localparam int NX = 10;
  localparam int NY = 9;
  localparam int CW = 9;
  localparam int MH = 16;

  logic          CLOCK_50;
  logic          Resetn;
  logic [NX-1:0] VGA_x;
  logic [NY-1:0] VGA_y;
  logic [CW-1:0] VGA_color;
  logic          VGA_write;
  logic          busy;
  logic [N-1:0]  timeout_err;

  int tests;
  int fails;

  vga_write_arbiter_if #(
    .N(N), .nX(NX), .nY(NY), .CW(CW)
  ) bus ();

  vga_write_arbiter #(
    .N(N), .nX(NX), .nY(NY), .CW(CW),
    .HOLD_W(17), .MAX_HOLD(MH)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .Resetn     (Resetn),
    .bus        (bus),
    .VGA_x      (VGA_x),
    .VGA_y      (VGA_y),
    .VGA_color  (VGA_color),
    .VGA_write  (VGA_write),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic nclk(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    Resetn = 1'b0;
    bus.req = '0;
    bus.obj_write = '0;
    bus.obj_x = '0;
    bus.obj_y = '0;
    bus.obj_color = '0;
    nclk(2);
    tests++;
    if (bus.gnt !== 4'b0000) begin
      fails++;
      $display("FAIL rst_gnt got %b exp 0000", bus.gnt);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy got %b exp 0", busy);
    end
    tests++;
    if (timeout_err !== 4'b0000) begin
      fails++;
      $display("FAIL rst_terr got %b exp 0000",
               timeout_err);
    end
    tests++;
    if (VGA_write !== 1'b0 || VGA_x !== '0) begin
      fails++;
      $display("FAIL rst_vga got w=%b x=%0d exp 0/0",
               VGA_write, VGA_x);
    end
    Resetn = 1'b1;
    nclk(1);
  endtask

  task automatic test_first_grant;
    bus.obj_x[0 +: NX]     = 10'd80;
    bus.obj_y[0 +: NY]     = 9'd400;
    bus.obj_color[0 +: CW] = 9'h1C0;
    bus.obj_x[2*NX +: NX]  = 10'd333;
    bus.obj_write = 4'b0001;
    bus.req = 4'b0001;
    nclk(1);
    tests++;
    if (bus.gnt !== 4'b0001 || busy !== 1'b1) begin
      fails++;
      $display("FAIL g1_gnt got %b/%b exp 0001/1",
               bus.gnt, busy);
    end
    tests++;
    if (VGA_write !== 1'b1) begin
      fails++;
      $display("FAIL g1_write got %b exp 1", VGA_write);
    end
    tests++;
    if (VGA_x !== 10'd80 || VGA_y !== 9'd400) begin
      fails++;
      $display("FAIL g1_xy got %0d,%0d exp 80,400",
               VGA_x, VGA_y);
    end
    tests++;
    if (VGA_color !== 9'h1C0) begin
      fails++;
      $display("FAIL g1_color got %h exp 1c0",
               VGA_color);
    end
  endtask

  task automatic test_ungranted_write;
    bus.obj_write = 4'b0100;
    #1;
    tests++;
    if (VGA_write !== 1'b0 || VGA_x !== 10'd80) begin
      fails++;
      $display("FAIL ungr_write got w=%b x=%0d exp 0/80",
               VGA_write, VGA_x);
    end
    bus.obj_write = 4'b0101;
    #1;
    tests++;
    if (VGA_write !== 1'b1) begin
      fails++;
      $display("FAIL own_write got %b exp 1", VGA_write);
    end
    bus.req = '0;
    bus.obj_write = '0;
    nclk(1);
    tests++;
    if (bus.gnt !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL gap_after got %b/%b exp 0000/0",
               bus.gnt, busy);
    end
    nclk(1);
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp_g;
    int gap;
    bit got;
    Resetn = 1'b0;
    nclk(1);
    Resetn = 1'b1;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      gap = 0;
      got = 0;
      for (int c = 0; c < 8 && !got; c++) begin
        nclk(1);
        if (bus.gnt !== 4'b0000) got = 1;
        else begin
          gap++;
          if (g < 4) bus.req = 4'b1111;
        end
      end
      tests++;
      if (!got || bus.gnt !== exp_g) begin
        fails++;
        $display("FAIL rr_order%0d got %b exp %b",
                 g, bus.gnt, exp_g);
      end
      // GAP cycle plus the IDLE arbitration cycle.
      tests++;
      if (gap !== ((g == 0) ? 0 : 2)) begin
        fails++;
        $display("FAIL rr_gap%0d got %0d exp %0d",
                 g, gap, (g == 0) ? 0 : 2);
      end
      nclk(9);
      tests++;
      if (bus.gnt !== exp_g) begin
        fails++;
        $display("FAIL rr_hold%0d got %b exp %b",
                 g, bus.gnt, exp_g);
      end
      if (g < 4) bus.req = 4'b1111 & ~exp_g;
      else bus.req = '0;
    end
    nclk(2);
  endtask

  task automatic test_wrap;
    bus.req = 4'b0010;
    nclk(1);
    tests++;
    if (bus.gnt !== 4'b0010) begin
      fails++;
      $display("FAIL wrap_pre got %b exp 0010", bus.gnt);
    end
    bus.req = '0;
    nclk(2);
    bus.req = 4'b0011;
    nclk(1);
    tests++;
    if (bus.gnt !== 4'b0001) begin
      fails++;
      $display("FAIL wrap_0 got %b exp 0001", bus.gnt);
    end
    bus.req = 4'b0010;
    nclk(1);
    tests++;
    if (bus.gnt !== 4'b0000) begin
      fails++;
      $display("FAIL wrap_gap got %b exp 0000", bus.gnt);
    end
    nclk(2);
    tests++;
    if (bus.gnt !== 4'b0010) begin
      fails++;
      $display("FAIL wrap_1 got %b exp 0010", bus.gnt);
    end
    bus.req = '0;
    nclk(2);
  endtask

  task automatic test_timeout;
    int cnt;
    int bad;
    bus.req = 4'b0010;
    nclk(1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.gnt !== 4'b0010) break;
      cnt++;
      nclk(1);
    end
    tests++;
    if (cnt !== MH) begin
      fails++;
      $display("FAIL to_len got %0d exp %0d", cnt, MH);
    end
    tests++;
    if (timeout_err !== 4'b0010 || busy !== 1'b0) begin
      fails++;
      $display("FAIL to_flag got %b/%b exp 0010/0",
               timeout_err, busy);
    end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      nclk(1);
      if (bus.gnt !== 4'b0000) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL to_lockout got %0d grants exp 0",
               bad);
    end
    bus.req = '0;
    nclk(1);
    bus.req = 4'b0010;
    nclk(1);
    tests++;
    if (bus.gnt !== 4'b0010) begin
      fails++;
      $display("FAIL to_regrant got %b exp 0010",
               bus.gnt);
    end
    tests++;
    if (timeout_err !== 4'b0010) begin
      fails++;
      $display("FAIL to_sticky got %b exp 0010",
               timeout_err);
    end
    bus.req = '0;
    nclk(2);
  endtask

  task automatic test_reset_mid_grant;
    int bad;
    bus.obj_write = 4'b0100;
    bus.req = 4'b0100;
    nclk(1);
    tests++;
    if (bus.gnt !== 4'b0100) begin
      fails++;
      $display("FAIL mr_gnt got %b exp 0100", bus.gnt);
    end
    bad = 0;
    for (int p = 0; p < 8; p++) begin
      bus.obj_x[2*NX +: NX] = NX'(492 + p);
      #1;
      if (VGA_x !== NX'(492 + p) || VGA_write !== 1'b1)
        bad++;
      nclk(1);
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL mr_pixels got %0d bad exp 0", bad);
    end
    Resetn = 1'b0;
    bus.req = 4'b0110;
    nclk(1);
    tests++;
    if (bus.gnt !== 4'b0000 || VGA_write !== 1'b0) begin
      fails++;
      $display("FAIL mr_drop got %b/%b exp 0000/0",
               bus.gnt, VGA_write);
    end
    tests++;
    if (timeout_err !== 4'b0000 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mr_clear got %b/%b exp 0000/0",
               timeout_err, busy);
    end
    Resetn = 1'b1;
    nclk(1);
    tests++;
    if (bus.gnt !== 4'b0010) begin
      fails++;
      $display("FAIL mr_ptr0 got %b exp 0010", bus.gnt);
    end
    bus.req = '0;
    bus.obj_write = '0;
    nclk(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_first_grant();
    test_ungranted_write();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
